sb_config_switch: RTL and testbench

SB_CONFIG_SWITCH -- requirements
Module: sb_config_switch

---
 rtl/sb_pkg.sv | 21 ++
 rtl/sb_track_mux.sv | 27 ++
 rtl/sb_config_switch.sv | 126 ++++++++++++
 tb/tb_sb_config_switch.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// sb_pkg : select encodings and chain FSM states for the switch box
// Rev 1.0
// ---------------------------------------------------------------
package sb_pkg;

  localparam logic [1:0] SEL_OFF = 2'b00;
  localparam logic [1:0] SEL_CW1 = 2'b01;
  localparam logic [1:0] SEL_CW2 = 2'b10;
  localparam logic [1:0] SEL_CW3 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FULL  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sb_track_mux.sv
`default_nettype none
// ---------------------------------------------------------------
// sb_track_mux : one output track, 3 neighbour sources or constant 0
// Rev 1.0
// ---------------------------------------------------------------
module sb_track_mux
  import sb_pkg::*;
(
  input  logic [1:0] i_sel,
  input  logic       i_d1,
  input  logic       i_d2,
  input  logic       i_d3,
  output logic       o_y
);

  always_comb begin
    o_y = 1'b0;
    case (i_sel)
      SEL_CW1: o_y = i_d1;
      SEL_CW2: o_y = i_d2;
      SEL_CW3: o_y = i_d3;
      default: o_y = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sb_config_switch.sv
`default_nettype none
// ---------------------------------------------------------------
// sb_config_switch : 4-sided switch box with serial shadow/active config
// Rev 1.0
// ---------------------------------------------------------------
module sb_config_switch
  import sb_pkg::*;
#(
  parameter int W       = 4,
  parameter bit OUT_REG = 1'b0
) (
  input  logic         prog_clk,
  input  logic         rst,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  input  logic [W-1:0] in4,
  output logic [W-1:0] out1,
  output logic [W-1:0] out2,
  output logic [W-1:0] out3,
  output logic [W-1:0] out4,
  input  logic         prog_in,
  input  logic         prog_en,
  input  logic         prog_load,
  input  logic         prog_rdbk,
  output logic         prog_out,
  output logic         cfg_valid,
  output logic         cfg_err,
  output logic [1:0]   cfg_state
);

  localparam int CFG_BITS = 8 * W;
  localparam int CNT_W    = $clog2(CFG_BITS + 2);
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] C_CNT_SAT  = CNT_W'(CFG_BITS + 1);

  logic [CFG_BITS-1:0] r_shadow;
  logic [CFG_BITS-1:0] r_active;
  logic [CNT_W-1:0]    r_cnt;
  state_t              r_state;
  logic                r_valid;
  logic                r_err;

  logic [CNT_W-1:0]    w_cnt_inc;
  state_t              w_state_inc;

  assign w_cnt_inc = (r_cnt == C_CNT_SAT) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state_inc = ST_SHIFT;
    if (w_cnt_inc == C_CNT_FULL)     w_state_inc = ST_FULL;
    else if (w_cnt_inc > C_CNT_FULL) w_state_inc = ST_OVER;
  end

  // load beats readback beats shift; the state always tracks the count
  always_ff @(posedge prog_clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_active <= '0;
      r_cnt    <= '0;
      r_state  <= ST_IDLE;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else if (prog_load) begin
      r_cnt   <= '0;
      r_state <= ST_IDLE;
      if (r_state == ST_FULL) begin
        r_active <= r_shadow;
        r_valid  <= 1'b1;
        r_err    <= 1'b0;
      end else begin
        r_err <= 1'b1;
      end
    end else if (prog_rdbk) begin
      r_shadow <= r_active;
      r_cnt    <= '0;
      r_state  <= ST_IDLE;
    end else if (prog_en) begin
      r_shadow <= {prog_in, r_shadow[CFG_BITS-1:1]};
      r_cnt    <= w_cnt_inc;
      r_state  <= w_state_inc;
    end
  end

  assign prog_out  = r_shadow[0];
  assign cfg_valid = r_valid;
  assign cfg_err   = r_err;
  assign cfg_state = r_state;

  logic [W-1:0]     w_in [4];
  logic [4*W-1:0]   w_route;
  logic [4*W-1:0]   w_gated;

  assign w_in[0] = in1;
  assign w_in[1] = in2;
  assign w_in[2] = in3;
  assign w_in[3] = in4;

  // sources walk clockwise from the next side, so a side never selects itself
  for (genvar k = 0; k < 4; k++) begin : g_side
    for (genvar i = 0; i < W; i++) begin : g_bit
      sb_track_mux u_mux (
        .i_sel (r_active[2*(k*W+i) +: 2]),
        .i_d1  (w_in[(k+1)%4][i]),
        .i_d2  (w_in[(k+2)%4][i]),
        .i_d3  (w_in[(k+3)%4][i]),
        .o_y   (w_route[k*W+i])
      );
    end
  end

  assign w_gated = w_route & {(4*W){r_valid}};

  if (OUT_REG) begin : g_out_reg
    logic [4*W-1:0] r_out;
    always_ff @(posedge prog_clk) begin
      if (rst) r_out <= '0;
      else     r_out <= w_gated;
    end
    assign {out4, out3, out2, out1} = r_out;
  end else begin : g_out_comb
    assign {out4, out3, out2, out1} = w_gated;
  end

endmodule
`default_nettype wire

// File: tb/tb_sb_config_switch.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_sb_config_switch : directed checks of chain, commit, routing, readback
// Rev 1.0
// ---------------------------------------------------------------
module tb_sb_config_switch;

  localparam int W = 4;
  localparam logic [31:0] C_PAT = 32'h1B1B_E4E4;

  logic         prog_clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0;
  logic         prog_in = 1'b0, prog_en = 1'b0, prog_load = 1'b0, prog_rdbk = 1'b0;
  logic [W-1:0] out1, out2, out3, out4;
  logic         prog_out, cfg_valid, cfg_err;
  logic [1:0]   cfg_state;
  logic [W-1:0] rout1, rout2, rout3, rout4;
  logic         rprog_out, rcfg_valid, rcfg_err;
  logic [1:0]   rcfg_state;

  int checks = 0;
  int errors = 0;

  always #5 prog_clk = ~prog_clk;

  sb_config_switch #(.W(W), .OUT_REG(1'b0)) u_dut (
    .prog_clk(prog_clk), .rst(rst),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4),
    .prog_in(prog_in), .prog_en(prog_en), .prog_load(prog_load), .prog_rdbk(prog_rdbk),
    .prog_out(prog_out), .cfg_valid(cfg_valid), .cfg_err(cfg_err), .cfg_state(cfg_state)
  );

  sb_config_switch #(.W(W), .OUT_REG(1'b1)) u_dut_reg (
    .prog_clk(prog_clk), .rst(rst),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .out1(rout1), .out2(rout2), .out3(rout3), .out4(rout4),
    .prog_in(prog_in), .prog_en(prog_en), .prog_load(prog_load), .prog_rdbk(prog_rdbk),
    .prog_out(rprog_out), .cfg_valid(rcfg_valid), .cfg_err(rcfg_err), .cfg_state(rcfg_state)
  );

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic shift_bits(input logic [63:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      prog_in = data[i];
      prog_en = 1'b1;
      tick();
    end
    prog_en = 1'b0;
    prog_in = 1'b0;
  endtask

  task automatic pulse_load();
    prog_load = 1'b1;
    tick();
    prog_load = 1'b0;
  endtask

  task automatic chk_outs(input string tag, input logic [W-1:0] e1, input logic [W-1:0] e2,
                          input logic [W-1:0] e3, input logic [W-1:0] e4);
    chk({tag, "_out1"}, 32'(out1), 32'(e1));
    chk({tag, "_out2"}, 32'(out2), 32'(e2));
    chk({tag, "_out3"}, 32'(out3), 32'(e3));
    chk({tag, "_out4"}, 32'(out4), 32'(e4));
  endtask

  initial begin
    // reset with all inputs high: everything must stay zero
    in1 = 4'hF; in2 = 4'hF; in3 = 4'hF; in4 = 4'hF;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_outs("rst", 4'h0, 4'h0, 4'h0, 4'h0);
    chk("rst_valid", 32'(cfg_valid), 32'd0);
    chk("rst_err",   32'(cfg_err),   32'd0);
    chk("rst_state", 32'(cfg_state), 32'd0);
    chk("rst_pout",  32'(prog_out),  32'd0);

    // all-ones commit: every select is 11
    in1 = 4'h3; in2 = 4'hA; in3 = 4'h5; in4 = 4'hC;
    shift_bits(64'hFFFF_FFFF, 31);
    chk("s31_state", 32'(cfg_state), 32'd1);
    shift_bits(64'h1, 1);
    chk("s32_state", 32'(cfg_state), 32'd2);
    pulse_load();
    chk("ld1_state", 32'(cfg_state), 32'd0);
    chk("ld1_valid", 32'(cfg_valid), 32'd1);
    chk("ld1_err",   32'(cfg_err),   32'd0);
    chk_outs("ld1", 4'hC, 4'h3, 4'hA, 4'h5);
    chk("reg_lat0", 32'(rout1), 32'h0);
    tick();
    chk("reg_lat1", 32'(rout1), 32'hC);

    // short chain rejected, prior routing kept
    shift_bits(64'h0, 31);
    pulse_load();
    chk("short_err",   32'(cfg_err),   32'd1);
    chk("short_state", 32'(cfg_state), 32'd0);
    chk_outs("short", 4'hC, 4'h3, 4'hA, 4'h5);

    // mixed pattern commit clears the error
    shift_bits(64'(C_PAT), 32);
    pulse_load();
    chk("pat_err", 32'(cfg_err), 32'd0);
    chk_outs("pat", 4'hE, 4'h4, 4'h6, 4'h3);
    in1 = 4'hF; in2 = 4'hF; in3 = 4'hF; in4 = 4'hF;
    #1;
    chk_outs("patF", 4'hE, 4'hE, 4'h7, 4'h7);

    // overlong chain rejected
    shift_bits(64'hFFFF_FFFF_FFFF, 33);
    chk("over_state", 32'(cfg_state), 32'd3);
    pulse_load();
    chk("over_err", 32'(cfg_err), 32'd1);
    chk_outs("over", 4'hE, 4'hE, 4'h7, 4'h7);

    // readback reproduces the active pattern LSB first
    prog_rdbk = 1'b1;
    tick();
    prog_rdbk = 1'b0;
    chk("rdbk_state", 32'(cfg_state), 32'd0);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("rdbk_bit%0d", i), 32'(prog_out), 32'(C_PAT[i]));
      shift_bits(64'h0, 1);
    end
    chk("rdbk_full", 32'(cfg_state), 32'd2);

    // load with simultaneous shift: shift must be dropped
    prog_rdbk = 1'b1;
    tick();
    prog_rdbk = 1'b0;
    in1 = 4'h3; in2 = 4'hA; in3 = 4'h5; in4 = 4'hC;
    shift_bits(64'hFFFF_FFFF, 32);
    prog_load = 1'b1; prog_en = 1'b1; prog_in = 1'b0;
    tick();
    prog_load = 1'b0; prog_en = 1'b0;
    chk("ldsh_state", 32'(cfg_state), 32'd0);
    chk("ldsh_err",   32'(cfg_err),   32'd0);
    chk_outs("ldsh", 4'hC, 4'h3, 4'hA, 4'h5);
    shift_bits(64'hFFFF_FFFF, 31);
    chk("ldsh_s31_state", 32'(cfg_state), 32'd1);
    chk("ldsh_s31_pout",  32'(prog_out),  32'd1);

    // reset, then reset again mid-shift at count 17
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_valid", 32'(cfg_valid), 32'd0);
    chk("rst2_out1",  32'(out1),      32'd0);
    shift_bits(64'h1_FFFF, 17);
    chk("mid_state", 32'(cfg_state), 32'd1);
    rst = 1'b1; prog_en = 1'b1; prog_in = 1'b1;
    tick();
    rst = 1'b0; prog_en = 1'b0; prog_in = 1'b0;
    chk("mid_rst_state", 32'(cfg_state), 32'd0);
    chk("mid_rst_valid", 32'(cfg_valid), 32'd0);
    chk("mid_rst_pout",  32'(prog_out),  32'd0);
    chk("mid_rst_out1",  32'(out1),      32'd0);
    chk("mid_rst_rout1", 32'(rout1),     32'd0);
    shift_bits(64'hFFFF, 15);
    chk("mid_s15_state", 32'(cfg_state), 32'd1);
    shift_bits(64'h1_FFFF, 17);
    chk("mid_s32_state", 32'(cfg_state), 32'd2);
    pulse_load();
    chk("mid_ld_valid", 32'(cfg_valid), 32'd1);
    chk_outs("mid_ld", 4'hC, 4'h3, 4'hA, 4'h5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
